// File: rtl/exe_branch_redirect.sv
// EXE-stage branch resolution: computes taken/target, strobes the IF redirect,
// sequences the IF/ID + ID/EX flush and keeps saturating branch statistics.
//
// state | meaning
// IDLE  | resolving branches presented by ID/EX
// FLUSH | redirect issued; flush held until the down-counter reaches zero
module exe_branch_redirect #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             freeze,
  input  logic [1:0]       Br_type,
  input  logic [31:0]      Val1,
  input  logic [31:0]      Reg2,
  input  logic [31:0]      Val2,
  input  logic [31:0]      PC_in,
  output logic             Br_taken,
  output logic [31:0]      Br_addr,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [3:0]       CNT_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              br_taken_n, flush_n, busy_n;
  logic [31:0]       br_addr_n;
  logic [CNT_W-1:0]  branch_count_n, taken_count_n;

  logic              cond;
  logic              sample;
  logic [31:0]       target;

  always_comb begin
    cond = 1'b0;
    case (Br_type)
      BR_BEZ:  cond = (Val1 == 32'd0);
      BR_BNE:  cond = (Val1 != Reg2);
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign target = PC_in + {Val2[29:0], 2'b00};
  assign sample = (state == IDLE) && !freeze && valid_in && (Br_type != BR_NONE);

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    br_taken_n     = Br_taken;
    br_addr_n      = Br_addr;
    flush_n        = flush;
    busy_n         = busy;
    branch_count_n = branch_count;
    taken_count_n  = taken_count;

    if (!freeze) begin
      case (state)
        IDLE: begin
          br_taken_n = 1'b0;
          flush_n    = 1'b0;
          busy_n     = 1'b0;
          if (sample) begin
            if (branch_count != {CNT_W{1'b1}})
              branch_count_n = branch_count + CNT_ONE;
            if (cond) begin
              if (taken_count != {CNT_W{1'b1}})
                taken_count_n = taken_count + CNT_ONE;
              br_taken_n = 1'b1;
              br_addr_n  = target;
              flush_n    = 1'b1;
              busy_n     = 1'b1;
              cnt_n      = CNT_LOAD;
              state_n    = FLUSH;
            end
          end
        end
        FLUSH: begin
          // Redirect strobe is one cycle; inputs here are wrong-path and ignored.
          br_taken_n = 1'b0;
          if (cnt == 4'd0) begin
            flush_n = 1'b0;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            cnt_n   = cnt - 4'd1;
            flush_n = 1'b1;
            busy_n  = 1'b1;
          end
        end
        default: begin
          br_taken_n = 1'b0;
          flush_n    = 1'b0;
          busy_n     = 1'b0;
          cnt_n      = 4'd0;
          state_n    = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      Br_taken     <= 1'b0;
      Br_addr      <= 32'd0;
      flush        <= 1'b0;
      busy         <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      Br_taken     <= br_taken_n;
      Br_addr      <= br_addr_n;
      flush        <= flush_n;
      busy         <= busy_n;
      branch_count <= branch_count_n;
      taken_count  <= taken_count_n;
    end
  end

endmodule
